// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 memory arbiter.
// Contents:
//   arb_state_e     : arbiter FSM states (ARB, LOCK)
//   DEF_ADDR_W      : default memory word-address width
//   DEF_DATA_W      : default memory data width
//   MAX_REQ         : largest supported number of requesting engines
//   owner_t         : engine id, wide enough for MAX_REQ engines
package sha256_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_DATA_W  = 32;
  localparam int MAX_REQ     = 8;
  localparam int OWNER_W_MAX = $clog2(MAX_REQ);

  typedef logic [OWNER_W_MAX-1:0] owner_t;

endpackage

// File: rtl/sha256_mem_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Searches the request vector upward from the priority pointer, wrapping
// modulo N, and returns the first set index.
// Ports:
//   req   in  N      request vector
//   ptr   in  IDX_W  index with highest priority
//   found out 1      at least one request is set
//   idx   out IDX_W  granted index (0 when nothing is found)
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  int cand;

  // NOTE: every variable written in an always_comb gets a default first so
  // no path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int i = 0; i < N; i++) begin
      cand = int'(ptr) + i;
      if (cand >= N) cand = cand - N;
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/sha256_mem_arbiter.sv
// Round-robin arbiter sharing one word-addressed memory port among NUM_REQ
// SHA-256 engines. Each grant locks the port to one engine for a burst of
// read or write beats; read data (1-cycle latency) is routed back to the
// engine that issued the read, even after ownership has moved on.
//
// Optional feature (macro SHA256_ARB_TIMEOUT_EN): an idle counter releases
// the lock after TIMEOUT consecutive LOCK cycles without a beat. Without the
// macro a stalled owner holds the lock indefinitely.
//
// Ports:
//   clk            in   single clock, rising edge
//   reset          in   synchronous active-high reset
//   req_valid      in   per-engine beat valid
//   req_we         in   per-engine write enable (1 = write beat)
//   req_last       in   per-engine last beat of burst
//   req_addr       in   packed per-engine word addresses
//   req_wdata      in   packed per-engine write data
//   req_ready      out  one-hot, current owner while locked
//   rsp_valid      out  one-hot pulse, read data valid for that engine
//   rsp_data       out  read data, broadcast to all engines
//   mem_clk        out  equals clk
//   mem_we         out  memory write enable
//   mem_addr       out  memory word address
//   mem_write_data out  memory write data
//   mem_read_data  in   memory read data, one cycle after the address
module sha256_mem_arbiter
  import sha256_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      mem_clk,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_write_data,
  input  logic [DATA_W-1:0]         mem_read_data
);

  localparam int OWN_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || MAX_BURST < 1 || TIMEOUT < 1) begin : g_bad_cfg
    $error("sha256_mem_arbiter: parameter out of range");
  end

  arb_state_e       state,    state_n;
  logic [OWN_W-1:0] owner,    owner_n;
  logic [OWN_W-1:0] ptr,      ptr_n;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_n;
  logic             rd_pend,  rd_pend_n;
  logic [OWN_W-1:0] rd_id,    rd_id_n;

`ifdef SHA256_ARB_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  logic [IDLE_W-1:0] idle_cnt, idle_cnt_n;
`endif

  logic             pick_found;
  logic [OWN_W-1:0] pick_idx;
  logic             beat;
  logic             release_lock;

  assign mem_clk = clk;

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (OWN_W)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign beat = (state == LOCK) && req_valid[owner];

  always_comb begin
    state_n        = state;
    owner_n        = owner;
    ptr_n          = ptr;
    beat_cnt_n     = beat_cnt;
    rd_pend_n      = 1'b0;
    rd_id_n        = rd_id;
    release_lock   = 1'b0;
    req_ready      = '0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
`ifdef SHA256_ARB_TIMEOUT_EN
    idle_cnt_n     = idle_cnt;
`endif

    case (state)
      ARB: begin
        if (pick_found) begin
          owner_n    = pick_idx;
          beat_cnt_n = '0;
          state_n    = LOCK;
        end
`ifdef SHA256_ARB_TIMEOUT_EN
        idle_cnt_n = '0;
`endif
      end

      LOCK: begin
        req_ready[owner] = 1'b1;
        if (beat) begin
          mem_we         = req_we[owner];
          mem_addr       = req_addr[owner*ADDR_W +: ADDR_W];
          mem_write_data = req_wdata[owner*DATA_W +: DATA_W];
          beat_cnt_n     = beat_cnt + 1'b1;
          if (!req_we[owner]) begin
            rd_pend_n = 1'b1;
            rd_id_n   = owner;
          end
          // beat_cnt counts beats already taken, so this is the MAX_BURST-th.
          if (req_last[owner] || beat_cnt == CNT_W'(MAX_BURST - 1))
            release_lock = 1'b1;
        end
`ifdef SHA256_ARB_TIMEOUT_EN
        if (beat) begin
          idle_cnt_n = '0;
        end else begin
          idle_cnt_n = idle_cnt + 1'b1;
          if (idle_cnt == IDLE_W'(TIMEOUT - 1))
            release_lock = 1'b1;
        end
`endif
        if (release_lock) begin
          state_n = ARB;
          ptr_n   = (owner == OWN_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
        end
      end

      default: state_n = ARB;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ARB;
      owner    <= '0;
      ptr      <= '0;
      beat_cnt <= '0;
      rd_pend  <= 1'b0;
      rd_id    <= '0;
`ifdef SHA256_ARB_TIMEOUT_EN
      idle_cnt <= '0;
`endif
    end else begin
      state    <= state_n;
      owner    <= owner_n;
      ptr      <= ptr_n;
      beat_cnt <= beat_cnt_n;
      rd_pend  <= rd_pend_n;
      rd_id    <= rd_id_n;
`ifdef SHA256_ARB_TIMEOUT_EN
      idle_cnt <= idle_cnt_n;
`endif
    end
  end

  // Memory returns data one cycle after the address, so the response is the
  // raw memory bus qualified by the registered read-pending flag.
  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    if (rd_pend) begin
      rsp_valid[rd_id] = 1'b1;
      rsp_data         = mem_read_data;
    end
  end

endmodule

// File: tb/tb_sha256_mem_arbiter.sv
// Directed self-checking bench for sha256_mem_arbiter (default parameters:
// 4 engines, 16-bit addresses, 32-bit data, MAX_BURST 16, TIMEOUT 8).
// The memory model returns {16'hA5A5, addr} one cycle after each address.
// Stall expectations follow SHA256_ARB_TIMEOUT_EN when it is defined.
module tb_sha256_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_we;
  logic [N-1:0]    req_last;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            mem_clk;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_write_data;
  logic [DW-1:0]   mem_read_data;

  int n_asserts = 0;
  int n_fail    = 0;

  sha256_mem_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_we         (req_we),
    .req_last       (req_last),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_ready      (req_ready),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .mem_clk        (mem_clk),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_read_data <= {16'hA5A5, mem_addr};

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int e, input logic [AW-1:0] a);
    req_addr[e*AW +: AW] = a;
  endtask

  task automatic set_wdata(input int e, input logic [DW-1:0] d);
    req_wdata[e*DW +: DW] = d;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int          order [3];
    logic [N-1:0] exp_r;
    int          e;

    order = '{0, 2, 3};
    reset     = 1'b1;
    req_valid = '0;
    req_we    = '0;
    req_last  = '0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (2) tick();
    reset = 1'b0;
    #1;

    // Reset state
    check("rst_req_ready", req_ready, 4'b0000);
    check("rst_rsp_valid", rsp_valid, 4'b0000);
    check("rst_rsp_data", rsp_data, 32'h0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 16'h0);
    check("rst_mem_wdata", mem_write_data, 32'h0);
    check("rst_mem_clk_hi", mem_clk, clk);

    // Single read burst, engine 1, 0x0010..0x0013
    req_valid = 4'b0010;
    set_addr(1, 16'h0010);
    #1;
    check("t1_arb_ready", req_ready, 4'b0000);
    check("t1_arb_mem_addr", mem_addr, 16'h0000);
    for (int k = 0; k < 4; k++) begin
      tick();
      set_addr(1, AW'(16'h0010 + k));
      req_last[1] = (k == 3);
      #1;
      check("t1_ready", req_ready, 4'b0010);
      check("t1_mem_addr", mem_addr, 16'h0010 + k);
      check("t1_mem_we", mem_we, 1'b0);
      if (k == 0) begin
        check("t1_no_rsp_first", rsp_valid, 4'b0000);
      end else begin
        check("t1_rsp_valid", rsp_valid, 4'b0010);
        check("t1_rsp_data", rsp_data, 32'hA5A5_0010 + k - 1);
      end
    end
    tick();
    req_valid = '0;
    req_last  = '0;
    #1;
    check("t1_back_to_arb", req_ready, 4'b0000);
    check("t1_last_rsp_valid", rsp_valid, 4'b0010);
    check("t1_last_rsp_data", rsp_data, 32'hA5A5_0013);
    check("t1_idle_addr", mem_addr, 16'h0000);
    tick();
    check("t1_rsp_done", rsp_valid, 4'b0000);

    // Contention from reset: engines 0, 2, 3 with 2-beat write bursts
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_valid = 4'b1101;
    req_we    = 4'b1101;
    req_last  = '0;
    set_addr(0, 16'h0200); set_wdata(0, 32'h0000_1000);
    set_addr(2, 16'h0220); set_wdata(2, 32'h0000_1002);
    set_addr(3, 16'h0230); set_wdata(3, 32'h0000_1003);
    #1;
    check("t2_arb_ready", req_ready, 4'b0000);
    for (int g = 0; g < 3; g++) begin
      e     = order[g];
      exp_r = 4'b0001 << e;
      for (int b = 0; b < 2; b++) begin
        tick();
        set_addr(e, AW'(16'h0200 + 16 * e + b));
        req_last[e] = (b == 1);
        #1;
        check("t2_grant_ready", req_ready, exp_r);
        check("t2_mem_addr", mem_addr, 16'h0200 + 16 * e + b);
        check("t2_mem_we", mem_we, 1'b1);
        check("t2_mem_wdata", mem_write_data, 32'h0000_1000 + e);
        check("t2_no_rsp", rsp_valid, 4'b0000);
      end
      tick();
      req_valid[e] = 1'b0;
      req_last[e]  = 1'b0;
      #1;
      check("t2_arb_gap", req_ready, 4'b0000);
    end
    // Pointer must have wrapped to 0: with all four requesting, 0 wins.
    req_valid = 4'b1111;
    req_we    = 4'b0000;
    req_last  = 4'b1111;
    tick();
    check("t2_ptr_wrapped", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    req_last  = '0;
    #1;
    check("t2_ptr_release", req_ready, 4'b0000);

    // Forced release: engine 0 streams 20 read beats without last
    req_valid = 4'b0001;
    #1;
    check("t3_arb_ready", req_ready, 4'b0000);
    for (int k = 0; k < 16; k++) begin
      tick();
      set_addr(0, AW'(16'h0300 + k));
      #1;
      check("t3_ready_a", req_ready, 4'b0001);
      check("t3_addr_a", mem_addr, 16'h0300 + k);
    end
    tick();
    check("t3_forced_release", req_ready, 4'b0000);
    check("t3_release_idle_addr", mem_addr, 16'h0000);
    check("t3_beat16_rsp_valid", rsp_valid, 4'b0001);
    check("t3_beat16_rsp_data", rsp_data, 32'hA5A5_030F);
    for (int k = 16; k < 20; k++) begin
      tick();
      set_addr(0, AW'(16'h0300 + k));
      req_last[0] = (k == 19);
      #1;
      check("t3_ready_b", req_ready, 4'b0001);
      check("t3_addr_b", mem_addr, 16'h0300 + k);
    end
    tick();
    req_valid = '0;
    req_last  = '0;
    #1;
    check("t3_done_ready", req_ready, 4'b0000);
    check("t3_last_rsp_data", rsp_data, 32'hA5A5_0313);

    // Write passthrough: engine 3 writes 0xdeadbeef to 0x0100
    req_valid = 4'b1000;
    req_we    = 4'b1000;
    req_last  = 4'b1000;
    set_addr(3, 16'h0100);
    set_wdata(3, 32'hDEAD_BEEF);
    #1;
    check("t4_arb_ready", req_ready, 4'b0000);
    check("t4_arb_mem_we", mem_we, 1'b0);
    tick();
    check("t4_ready", req_ready, 4'b1000);
    check("t4_mem_we", mem_we, 1'b1);
    check("t4_mem_addr", mem_addr, 16'h0100);
    check("t4_mem_wdata", mem_write_data, 32'hDEAD_BEEF);
    tick();
    req_valid = '0;
    req_we    = '0;
    req_last  = '0;
    #1;
    check("t4_no_rsp", rsp_valid, 4'b0000);
    check("t4_we_low", mem_we, 1'b0);
    check("t4_wdata_idle", mem_write_data, 32'h0);
    check("t4_released", req_ready, 4'b0000);

    // Stall: engine 2 takes one read beat then drops valid for 10 cycles
    req_valid = 4'b0100;
    set_addr(2, 16'h0400);
    #1;
    check("t5_arb_ready", req_ready, 4'b0000);
    tick();
    check("t5_beat_ready", req_ready, 4'b0100);
    check("t5_beat_addr", mem_addr, 16'h0400);
    for (int s = 1; s <= 10; s++) begin
      tick();
      req_valid = '0;
      #1;
`ifdef SHA256_ARB_TIMEOUT_EN
      exp_r = (s <= 8) ? 4'b0100 : 4'b0000;
`else
      exp_r = 4'b0100;
`endif
      check("t5_stall_ready", req_ready, exp_r);
      check("t5_stall_addr", mem_addr, 16'h0000);
      if (s == 1) begin
        check("t5_stall_rsp_valid", rsp_valid, 4'b0100);
        check("t5_stall_rsp_data", rsp_data, 32'hA5A5_0400);
      end else begin
        check("t5_stall_no_rsp", rsp_valid, 4'b0000);
      end
    end
    tick();
    req_valid = 4'b0100;
    set_addr(2, 16'h0401);
    #1;
`ifdef SHA256_ARB_TIMEOUT_EN
    check("t5_regrant_arb", req_ready, 4'b0000);
    tick();
`endif
    check("t5_resume_ready", req_ready, 4'b0100);
    check("t5_resume_addr", mem_addr, 16'h0401);
    // Reset is sampled at the same edge that would register the read.
    reset = 1'b1;
    tick();
    check("t5_reset_rsp_suppressed", rsp_valid, 4'b0000);
    check("t5_reset_rsp_data", rsp_data, 32'h0);
    check("t5_reset_ready", req_ready, 4'b0000);
    check("t5_reset_addr", mem_addr, 16'h0000);
    reset     = 1'b0;
    req_valid = '0;
    tick();
    check("t5_after_reset_rsp", rsp_valid, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
